hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core; drives PC write enable, IF/ID write enable and flush, ID/EX bubble insertion and back-end freeze.
- Detects load-use hazards and taken branches resolved in ID.
- Handles a multi-cycle data-memory handshake and instruction-fetch wait.
- Keeps saturating stall and flush counters plus a sticky memory-timeout error flag.

---
 rtl/hazard_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline sequencing controller for the 5-stage core. Decides, every cycle,
// whether the front end advances, holds or squashes, whether a bubble enters
// ID/EX and whether the back end freezes for a slow data-memory access.
//
// Ports
//   clk_i, rst_i      clock; asynchronous active-high reset
//   id_rs1_i/rs2_i    source registers of the instruction in ID
//   id_uses_rs2_i     ID instruction actually reads rs2
//   ex_memread_i      EX instruction is a load
//   ex_rd_i           destination register of the EX instruction
//   branch_taken_i    branch/jump resolved taken in ID
//   imem_ready_i      fetch data valid this cycle
//   mem_req_i         MEM stage data access (held until acked)
//   mem_ack_i         data memory completes the access this cycle
//   pc_we_o           PC loads next value
//   ifid_we_o         IF/ID captures (1) or holds (0)
//   ifid_flush_o      IF/ID loads a NOP when captured
//   idex_bubble_o     zero control fields entering ID/EX
//   freeze_o          hold ID/EX, EX/MEM and MEM/WB
//   stall_cnt_o       saturating count of cycles with pc_we_o=0
//   flush_cnt_o       saturating count of taken-branch flushes
//   err_o             sticky data-memory timeout
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_uses_rs2_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             branch_taken_i,
   input  logic             imem_ready_i,
   input  logic             mem_req_i,
   input  logic             mem_ack_i,
   output logic             pc_we_o,
   output logic             ifid_we_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             freeze_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
   output logic             err_o
);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      MWAIT = 1'b1
   } state_e;

   localparam logic [TO_W-1:0]  TO_VAL  = TO_W'(TIMEOUT);
   localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_e           state_q, state_d;
   logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic lu_s;
   logic mstall_s;
   logic pc_we_s, ifid_we_s, ifid_flush_s, idex_bubble_s, freeze_s;
   logic branch_qual_s;

   // Hazard detection: x0 is never a real dependency; rs2 only counts when read.
   always_comb begin
      lu_s     = ex_memread_i & (ex_rd_i != 5'd0) &
                 ((ex_rd_i == id_rs1_i) | (id_uses_rs2_i & (ex_rd_i == id_rs2_i)));
      mstall_s = mem_req_i & ~mem_ack_i;
   end

   // Next-state, wait/timeout tracking, counters and raw control outputs.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      err_d         = err_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      pc_we_s       = 1'b1;
      ifid_we_s     = 1'b1;
      ifid_flush_s  = 1'b0;
      idex_bubble_s = 1'b0;
      freeze_s      = 1'b0;
      branch_qual_s = 1'b0;

      case (state_q)
         RUN: begin
            // Branch operands are only trustworthy when no stall is pending,
            // hence the strict priority order below.
            if (mstall_s) begin
               pc_we_s    = 1'b0;
               ifid_we_s  = 1'b0;
               freeze_s   = 1'b1;
               state_d    = MWAIT;
               wait_cnt_d = TO_ONE;
               if (TO_ONE == TO_VAL) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end else if (lu_s) begin
               pc_we_s       = 1'b0;
               ifid_we_s     = 1'b0;
               idex_bubble_s = 1'b1;
            end else if (branch_taken_i) begin
               ifid_flush_s  = 1'b1;
               branch_qual_s = 1'b1;
            end else if (!imem_ready_i) begin
               pc_we_s      = 1'b0;
               ifid_flush_s = 1'b1;
            end else begin
               pc_we_s = 1'b1;
            end
         end
         MWAIT: begin
            pc_we_s   = 1'b0;
            ifid_we_s = 1'b0;
            if (mem_ack_i) begin
               // Back end consumes the acked data this cycle; front end still holds.
               freeze_s   = 1'b0;
               state_d    = RUN;
               wait_cnt_d = '0;
            end else begin
               freeze_s = 1'b1;
               if (wait_cnt_q != TO_VAL) begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q;
               end
               if (wait_cnt_d == TO_VAL) begin
                  err_d = 1'b1;
               end else begin
                  err_d = err_q;
               end
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (!pc_we_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (branch_qual_s && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State, wait counter, error flag and statistics registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         err_q       <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         err_q       <= err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // While reset is held the pipeline is forced to a safe squashing posture.
   always_comb begin
      if (rst_i) begin
         pc_we_o       = 1'b0;
         ifid_we_o     = 1'b1;
         ifid_flush_o  = 1'b1;
         idex_bubble_o = 1'b1;
         freeze_o      = 1'b0;
      end else begin
         pc_we_o       = pc_we_s;
         ifid_we_o     = ifid_we_s;
         ifid_flush_o  = ifid_flush_s;
         idex_bubble_o = idex_bubble_s;
         freeze_o      = freeze_s;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed and randomized stimulus for hazard_ctrl, checked cycle by cycle
// against a behavioural model of the sequencing rules.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int CNT_W   = 8;
   localparam int TIMEOUT = 3;
   localparam int TO_W    = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk_i = 1'b0;
   logic             rst_i = 1'b0;
   logic [4:0]       id_rs1_i = 5'd0;
   logic [4:0]       id_rs2_i = 5'd0;
   logic             id_uses_rs2_i = 1'b0;
   logic             ex_memread_i = 1'b0;
   logic [4:0]       ex_rd_i = 5'd0;
   logic             branch_taken_i = 1'b0;
   logic             imem_ready_i = 1'b1;
   logic             mem_req_i = 1'b0;
   logic             mem_ack_i = 1'b0;
   logic             pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, freeze_o;
   logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
   logic             err_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_wait;
   int m_wcnt;
   bit m_err;
   int m_stall;
   int m_flush;

   hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_uses_rs2_i(id_uses_rs2_i),
      .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
      .branch_taken_i(branch_taken_i), .imem_ready_i(imem_ready_i),
      .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
      .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
      .idex_bubble_o(idex_bubble_o), .freeze_o(freeze_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] ctrl_now();
      return {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, freeze_o};
   endfunction

   task automatic model_reset();
      m_wait = 0; m_wcnt = 0; m_err = 0; m_stall = 0; m_flush = 0;
   endtask

   task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                         input logic mr, input logic [4:0] rd, input logic br,
                         input logic ir, input logic req, input logic ack);
      id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = u2; ex_memread_i = mr;
      ex_rd_i = rd; branch_taken_i = br; imem_ready_i = ir;
      mem_req_i = req; mem_ack_i = ack;
   endtask

   // One clock cycle: check all outputs against the model, then advance it.
   task automatic cyc();
      logic [4:0] e;
      bit qbr, lu, ms;
      #4;
      lu  = ex_memread_i && (ex_rd_i != 5'd0) &&
            ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
      ms  = mem_req_i && !mem_ack_i;
      qbr = 0;
      if (rst_i)                e = 5'b01110;
      else if (m_wait)          e = mem_ack_i ? 5'b00000 : 5'b00001;
      else if (ms)              e = 5'b00001;
      else if (lu)              e = 5'b00010;
      else if (branch_taken_i) begin e = 5'b11100; qbr = 1; end
      else if (!imem_ready_i)   e = 5'b01100;
      else                      e = 5'b11000;
      chk("ctrl", 32'(ctrl_now()), 32'(e));
      chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
      chk("flush_cnt", 32'(flush_cnt_o), 32'(m_flush));
      chk("err", 32'(err_o), 32'(m_err));
      @(posedge clk_i);
      if (rst_i) begin
         model_reset();
      end else begin
         if (!e[4] && m_stall < CNT_MAX) m_stall++;
         if (qbr && m_flush < CNT_MAX) m_flush++;
         if (m_wait) begin
            if (mem_ack_i) begin
               m_wait = 0; m_wcnt = 0;
            end else begin
               if (m_wcnt < TIMEOUT) m_wcnt++;
               if (m_wcnt >= TIMEOUT) m_err = 1;
            end
         end else if (ms) begin
            m_wait = 1; m_wcnt = 1;
            if (m_wcnt >= TIMEOUT) m_err = 1;
         end
      end
      #1;
   endtask

   // Asynchronous reset pulse starting mid-cycle; outputs must react at once.
   task automatic async_reset();
      #2 rst_i = 1'b1;
      #1;
      chk("rst_ctrl", 32'(ctrl_now()), 32'(5'b01110));
      chk("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      chk("rst_flush_cnt", 32'(flush_cnt_o), 32'd0);
      chk("rst_err", 32'(err_o), 32'd0);
      model_reset();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      bit pend;
      model_reset();
      #1 rst_i = 1'b1;
      #1;
      chk("init_rst_ctrl", 32'(ctrl_now()), 32'(5'b01110));
      chk("init_rst_cnt", 32'(stall_cnt_o), 32'd0);
      chk("init_rst_err", 32'(err_o), 32'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Load-use on rs1: exactly one stall cycle
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("lu_pc_we", 32'(pc_we_o), 32'd0);
      chk("lu_bubble", 32'(idex_bubble_o), 32'd1);
      cyc();
      chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
      set_in(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("lu_release", 32'(pc_we_o), 32'd1);
      cyc();

      // rs2 match only counts when rs2 is read; x0 never stalls
      set_in(5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("rs2_unused", 32'(pc_we_o), 32'd1);
      cyc();
      set_in(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("rs2_used", 32'(pc_we_o), 32'd0);
      cyc();
      set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("rd_zero", 32'(pc_we_o), 32'd1);
      cyc();

      // Branch masked by load-use, then taken next cycle
      set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 chk("br_lu_flush", 32'(ifid_flush_o), 32'd0);
      cyc();
      chk("br_lu_flush_cnt", 32'(flush_cnt_o), 32'd0);
      set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
      #1 chk("br_flush", 32'(ifid_flush_o), 32'd1);
      chk("br_pc_we", 32'(pc_we_o), 32'd1);
      cyc();
      chk("br_flush_cnt", 32'(flush_cnt_o), 32'd1);

      // Fetch not ready
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1 chk("imem_pc_we", 32'(pc_we_o), 32'd0);
      chk("imem_flush", 32'(ifid_flush_o), 32'd1);
      cyc();

      // Memory wait: four stalled cycles then ack
      async_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
         #1 chk("mw_freeze", 32'(freeze_o), 32'd1);
         cyc();
      end
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      #1 chk("mw_ack_freeze", 32'(freeze_o), 32'd0);
      chk("mw_ack_pc_we", 32'(pc_we_o), 32'd0);
      cyc();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1 chk("mw_run_ctrl", 32'(ctrl_now()), 32'(5'b11000));
      chk("mw_stall_cnt", 32'(stall_cnt_o), 32'd5);
      cyc();

      // Timeout: err after TIMEOUT stalled cycles, sticky over ack
      async_reset();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc();
      cyc();
      chk("to_err_early", 32'(err_o), 32'd0);
      cyc();
      chk("to_err_set", 32'(err_o), 32'd1);
      cyc();
      cyc();
      mem_ack_i = 1'b1;
      cyc();
      chk("to_err_sticky", 32'(err_o), 32'd1);
      mem_ack_i = 1'b0;
      cyc();
      async_reset();
      chk("to_err_cleared", 32'(err_o), 32'd0);

      // Single-cycle access in RUN does not stall
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
      #1 chk("single_cycle", 32'(pc_we_o), 32'd1);
      cyc();

      // Randomized traffic, long enough to saturate the stall counter
      pend = 0;
      for (int n = 0; n < 700; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset();
            pend = 0;
         end
         id_rs1_i       = 5'($urandom_range(0, 3));
         id_rs2_i       = 5'($urandom_range(0, 3));
         id_uses_rs2_i  = 1'($urandom_range(0, 1));
         ex_memread_i   = 1'($urandom_range(0, 1));
         ex_rd_i        = 5'($urandom_range(0, 3));
         branch_taken_i = 1'($urandom_range(0, 2) == 0);
         imem_ready_i   = 1'($urandom_range(0, 4) != 0);
         mem_req_i      = pend ? 1'b1 : 1'($urandom_range(0, 3) == 0);
         mem_ack_i      = mem_req_i ? 1'($urandom_range(0, 3) == 0) : 1'b0;
         pend           = mem_req_i && !mem_ack_i;
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
